// File: rtl/uart_tx_frame.sv
// UART transmitter: serializes one byte as start, 7/8 data bits (LSB first),
// optional even/odd parity and 1 or 2 stop bits. All outputs are registered.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    input  logic       data_length,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       stop_two,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             len8;
    logic             par_en;
    logic             par_odd;
    logic             stop2;
    logic             stop_idx;
    logic             par_acc;
    logic             bit_end;
    logic [2:0]       last_idx;

    assign bit_end  = (cnt == CNT_LAST);
    assign last_idx = len8 ? 3'd7 : 3'd6;

    // Baud counter: parked at zero while idle so an accepted start begins a full bit.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt <= '0;
        end else if (state == IDLE || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_idx  <= '0;
            shreg    <= '0;
            len8     <= 1'b0;
            par_en   <= 1'b0;
            par_odd  <= 1'b0;
            stop2    <= 1'b0;
            stop_idx <= 1'b0;
            par_acc  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (tx_start) begin
                        shreg   <= data_in;
                        len8    <= data_length;
                        par_en  <= parity_en;
                        par_odd <= parity_odd;
                        stop2   <= stop_two;
                        par_acc <= 1'b0;
                        bit_idx <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        // The shift register always presents the bit on the line at [0].
                        shreg   <= {1'b0, shreg[7:1]};
                        par_acc <= par_acc ^ shreg[0];
                        if (bit_idx == last_idx) begin
                            stop_idx <= 1'b0;
                            if (par_en) begin
                                state <= PARITY;
                                tx    <= par_acc ^ shreg[0] ^ par_odd;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        tx       <= 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (stop2 && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle queue model of the line plus directed
// literal frame checks and a randomized soak with occasional async resets.
module tb_uart_tx_frame;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_length = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       stop_two = 1'b0;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(C), .CNT_W(3)) dut (
        .clk(clk), .arst(arst), .tx_start(tx_start), .data_in(data_in),
        .data_length(data_length), .parity_en(parity_en), .parity_odd(parity_odd),
        .stop_two(stop_two), .tx(tx), .busy(busy), .done(done)
    );

    // Model: queue holding the expected line value for every remaining busy cycle.
    bit   exp_q[$];
    logic exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;

    function automatic void build(input logic [7:0] d, input logic l8, input logic pen,
                                  input logic podd, input logic s2);
        int n;
        bit p;
        n = l8 ? 8 : 7;
        p = podd;
        for (int k = 0; k < C; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            p = p ^ d[i];
            for (int k = 0; k < C; k++) exp_q.push_back(d[i]);
        end
        if (pen) for (int k = 0; k < C; k++) exp_q.push_back(p);
        for (int k = 0; k < C * (s2 ? 2 : 1); k++) exp_q.push_back(1'b1);
    endfunction

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            exp_q.delete();
            exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            bit was_idle;
            was_idle = (exp_q.size() == 0);
            exp_done = 1'b0;
            if (!was_idle) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
            if (was_idle && tx_start) build(data_in, data_length, parity_en, parity_odd, stop_two);
            exp_tx   = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
            exp_busy = (exp_q.size() != 0);
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got tx=%b busy=%b done=%b expected tx=%b busy=%b done=%b",
                     $time, tx, busy, done, exp_tx, exp_busy, exp_done);
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    logic tx_s[64], busy_s[64], done_s[64];
    int   ncap;

    task automatic capture(input int n, input int inj_at, input logic [7:0] inj_d, input bit stop_on_done);
        ncap = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            tx_s[i] = tx; busy_s[i] = busy; done_s[i] = done; ncap = i + 1;
            if (inj_at >= 0 && i == inj_at) begin
                data_in = inj_d; tx_start = 1'b1;
            end else if (inj_at >= 0 && i == inj_at + 1) begin
                tx_start = 1'b0;
            end
            if (stop_on_done && done) break;
        end
    endtask

    function automatic int pattern(input int nbits);
        int p;
        p = 0;
        for (int b = 0; b < nbits; b++) if (tx_s[b*C+2] === 1'b1) p |= (1 << b);
        return p;
    endfunction

    function automatic int count_busy();
        int c;
        c = 0;
        for (int i = 0; i < ncap; i++) if (busy_s[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_done();
        int c;
        c = 0;
        for (int i = 0; i < ncap; i++) if (done_s[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int done_idx();
        for (int i = 0; i < ncap; i++) if (done_s[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic start_frame(input logic [7:0] d, input logic l8, input logic pen,
                               input logic podd, input logic s2);
        @(negedge clk);
        data_in = d; data_length = l8; parity_en = pen; parity_odd = podd; stop_two = s2;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    initial begin
        #1 arst = 1'b1;
        #10 arst = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        start_frame(8'hA5, 1, 0, 0, 0);
        capture(48, -1, 8'h00, 0);
        chk("t1_pattern", pattern(10), 'h34A);
        chk("t1_busy_cycles", count_busy(), 40);
        chk("t1_done_idx", done_idx(), 40);
        chk("t1_done_count", count_done(), 1);

        start_frame(8'hC1, 0, 1, 0, 0);
        capture(48, -1, 8'h00, 0);
        chk("t2_even_pattern", pattern(10), 'h282);
        chk("t2_even_busy", count_busy(), 40);

        start_frame(8'hC1, 0, 1, 1, 0);
        capture(48, -1, 8'h00, 0);
        chk("t2_odd_pattern", pattern(10), 'h382);
        chk("t2_odd_busy", count_busy(), 40);

        start_frame(8'h00, 1, 0, 0, 1);
        capture(52, -1, 8'h00, 0);
        chk("t3_pattern", pattern(11), 'h600);
        chk("t3_busy_cycles", count_busy(), 44);
        chk("t3_done_idx", done_idx(), 44);

        start_frame(8'hA5, 1, 0, 0, 0);
        capture(60, 14, 8'h55, 1);
        chk("t4_pattern", pattern(10), 'h34A);
        chk("t4_done_idx", ncap - 1, 40);
        chk("t4_done_count", count_done(), 1);
        chk("t4_done_tx", tx_s[ncap-1], 1);
        data_in = 8'h3C; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        capture(60, -1, 8'h00, 1);
        chk("t4_b2b_tx0", tx_s[0], 0);
        chk("t4_b2b_busy0", busy_s[0], 1);
        chk("t4_b2b_pattern", pattern(10), 'h278);
        chk("t4_b2b_done_idx", ncap - 1, 40);

        start_frame(8'hA5, 1, 0, 0, 0);
        repeat (17) @(negedge clk);
        #2 arst = 1'b1; tx_start = 1'b1; data_in = 8'hFF;
        #1;
        chk("t5_async_tx", tx, 1);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_done", done, 0);
        #9 arst = 1'b0; tx_start = 1'b0;
        @(negedge clk);
        capture(20, -1, 8'h00, 0);
        chk("t5_idle_busy", count_busy(), 0);
        chk("t5_idle_done", count_done(), 0);
        chk("t5_idle_tx_low", 20 - pattern_ones(), 0);
        start_frame(8'hFF, 1, 0, 0, 0);
        capture(48, -1, 8'h00, 0);
        chk("t5_ff_pattern", pattern(10), 'h3FE);
        chk("t5_ff_busy", count_busy(), 40);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            data_in     = 8'($urandom);
            data_length = 1'($urandom);
            parity_en   = 1'($urandom);
            parity_odd  = 1'($urandom);
            stop_two    = 1'($urandom);
            tx_start    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 arst = 1'b1;
                #6 arst = 1'b0;
            end
        end
        tx_start = 1'b0;
        repeat (60) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic int pattern_ones();
        int c;
        c = 0;
        for (int i = 0; i < ncap; i++) if (tx_s[i] === 1'b1) c++;
        return c;
    endfunction

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter serializing one parallel byte into an asynchronous frame on a single output line. It is the transmit-side counterpart of the receive data path, so its frame format must match the receiver's.
- Supports 7- or 8-bit data, optional even/odd parity, and 1 or 2 stop bits.
- Generates its own bit timing from the system clock.
- Sits between the host-side byte source (simple start/busy handshake) and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range >= 2
CNT_W, 10, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT

Ports:
clk  input  1  system clock, all logic on rising edge
arst  input  1  asynchronous reset, active-high
tx_start  input  1  request to send data_in; sampled each rising edge
data_in  input  8  byte to transmit; captured on accepted tx_start
data_length  input  1  1 = 8 data bits, 0 = 7 data bits (data_in[7] not sent); captured with data
parity_en  input  1  1 = append parity bit; captured with data
parity_odd  input  1  1 = odd parity, 0 = even parity; captured with data
stop_two  input  1  1 = two stop bits, 0 = one stop bit; captured with data
tx  output  1  serial line, idles high
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (arst high, asynchronous, any time including mid-frame):
  - tx=1, busy=0, done=0, state=IDLE, counters cleared, shift register cleared.
  - The partial frame is abandoned. After reset release the line stays high until a new tx_start.
- All outputs are registered. tx never glitches.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0.
  - tx_start=1 at edge k is accepted.
  - At edge k: latch data_in, data_length, parity_en, parity_odd, stop_two; go to START; tx=0; busy=1; baud counter=0.
  - Input changes after edge k have no effect on the frame.
- tx_start while busy=1 is ignored. There is no queuing.
- Each bit is held for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1; at terminal count the FSM advances and the counter resets to 0.
- START: one bit of 0, then go to DATA with bit index 0.
- DATA:
  - Data is sent LSB first. N = 8 if data_length latched 1, else 7.
  - After bit N-1, go to PARITY if parity_en, else STOP.
- PARITY:
  - Bit value = XOR of the N transmitted data bits, XOR parity_odd.
  - Latched data_in[7] is excluded from parity when N=7.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT when stop_two.
  - At the end of the last stop bit: go to IDLE, busy=0, done=1 for exactly one cycle.
- Frame length = (1 + N + P + S) * CLKS_PER_BIT cycles, with P in {0,1} and S in {1,2}. Measured from edge k to the edge where busy falls.
- Back-to-back frames:
  - tx_start high in the cycle done=1 (FSM in IDLE) is accepted at that edge.
  - The new start bit begins immediately, with no extra idle bit.
  - tx stays high through the STOP-to-IDLE transition.
- Simultaneous arst and tx_start: reset wins and nothing is accepted.

Test Plan:
1. CLKS_PER_BIT=4, reset, then tx_start with data_in=0xA5, data_length=1, parity_en=0, stop_two=0.
   - tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles.
   - busy high for 40 cycles; done pulses once at cycle 40.
2. data_in=0xC1, data_length=0, parity_en=1, parity_odd=0.
   - 7 data bits 1,0,0,0,0,0,1, then parity 0, then stop 1.
   - Bit 7 is never driven. Frame is 40 cycles.
   - Repeat with parity_odd=1: parity bit 1.
3. stop_two=1 with 0x00, 8-bit, no parity.
   - Eight 0 data bits, then tx high for 8 cycles; busy=1 for 44 cycles total.
4. Pulse tx_start with 0x55 while a 0xA5 frame is at bit 3.
   - Ignored: the 0xA5 waveform is unchanged and exactly one done pulse occurs.
   - Then assert tx_start with 0x3C in the done cycle: the next start bit begins on that edge, with no idle gap.
5. Assert arst at cycle 17 of a frame, for 1 cycle, asynchronous to clk.
   - tx=1, busy=0, done=0 immediately.
   - No done pulse follows; the line stays high until the next tx_start.
   - The next frame, 0xFF, is transmitted correctly.
